// File: rtl/adder_share_sched_pkg.sv
// adder_share_sched_pkg
//   Shared definitions for the adder-sharing scheduler:
//   - scheduler state encodings and the state enum built from them
//   - id_width(): width of a requester index for a given requester count
package adder_share_sched_pkg;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_ISSUE_ENC = 3'd1;
  localparam logic [2:0] ST_WAIT_ENC  = 3'd2;
  localparam logic [2:0] ST_RESP_ENC  = 3'd3;
  localparam logic [2:0] ST_CLEAR_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_ISSUE = ST_ISSUE_ENC,
    ST_WAIT  = ST_WAIT_ENC,
    ST_RESP  = ST_RESP_ENC,
    ST_CLEAR = ST_CLEAR_ENC
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_share_sched_if.sv
// adder_share_sched_if
//   Bundles the requester handshakes, the response channel, the shared
//   adder connection and the operation counter of adder_share_sched.
//   Modports:
//     slave  - the scheduler (accepts requests, drives response and adder)
//     master - the environment (requesters, response consumer, adder)
//   Signals:
//     REQ_VALID/REQ_A/REQ_B/REQ_READY     per-requester operand handshake
//     RSP_VALID/RSP_READY/RSP_ID/RSP_DATA/RSP_ERR   result channel
//     ADD_VAL1/ADD_VAL2/ADD_VAL1_VALID/ADD_VAL2_VALID/ADD_RST   to adder
//     ADD_IS_READY/ADD_OUTPUT_VAL/ADD_OUTPUT_VALID             from adder
//     OP_COUNT                            completed operation count
interface adder_share_sched_if
  import adder_share_sched_pkg::*;
#(
  parameter int ADDER_WIDTH = 4,
  parameter int NUM_REQ     = 4
);
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]             REQ_VALID;
  logic [NUM_REQ*ADDER_WIDTH-1:0] REQ_A;
  logic [NUM_REQ*ADDER_WIDTH-1:0] REQ_B;
  logic [NUM_REQ-1:0]             REQ_READY;

  logic                           RSP_VALID;
  logic                           RSP_READY;
  logic [ID_W-1:0]                RSP_ID;
  logic [ADDER_WIDTH-1:0]         RSP_DATA;
  logic                           RSP_ERR;

  logic [ADDER_WIDTH-1:0]         ADD_VAL1;
  logic [ADDER_WIDTH-1:0]         ADD_VAL2;
  logic                           ADD_VAL1_VALID;
  logic                           ADD_VAL2_VALID;
  logic                           ADD_RST;
  logic                           ADD_IS_READY;
  logic [ADDER_WIDTH-1:0]         ADD_OUTPUT_VAL;
  logic                           ADD_OUTPUT_VALID;

  logic [15:0]                    OP_COUNT;

  modport slave (
    input  REQ_VALID, REQ_A, REQ_B, RSP_READY,
           ADD_IS_READY, ADD_OUTPUT_VAL, ADD_OUTPUT_VALID,
    output REQ_READY, RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR,
           ADD_VAL1, ADD_VAL2, ADD_VAL1_VALID, ADD_VAL2_VALID, ADD_RST,
           OP_COUNT
  );

  modport master (
    output REQ_VALID, REQ_A, REQ_B, RSP_READY,
           ADD_IS_READY, ADD_OUTPUT_VAL, ADD_OUTPUT_VALID,
    input  REQ_READY, RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR,
           ADD_VAL1, ADD_VAL2, ADD_VAL1_VALID, ADD_VAL2_VALID, ADD_RST,
           OP_COUNT
  );

endinterface

// File: rtl/adder_share_sched_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin priority encoder. Searches req circularly
//   starting at index ptr and returns the first set position.
//   Ports:
//     req        in   NUM_REQ  request vector
//     ptr        in   ID_W     search start index (must be < NUM_REQ)
//     grant_idx  out  ID_W     index of the winning request (0 if none)
//     grant_any  out  1        at least one request is set
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  // cand_idx[k] is the requester examined k-th, i.e. (ptr + k) mod NUM_REQ.
  logic [ID_W-1:0]    cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] rot_req;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [ID_W:0] sum_w;
    logic [ID_W:0] wrap_w;
    assign sum_w  = {1'b0, ptr} + (ID_W+1)'(gi);
    assign wrap_w = sum_w - (ID_W+1)'(NUM_REQ);
    // ptr < NUM_REQ, so a single conditional subtract is a full modulo.
    assign cand_idx[gi] = (sum_w >= (ID_W+1)'(NUM_REQ)) ? wrap_w[ID_W-1:0]
                                                        : sum_w[ID_W-1:0];
    assign rot_req[gi]  = req[cand_idx[gi]];
  end

  // Walk from the farthest offset down so the nearest set request wins.
  always_comb begin
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        grant_idx = cand_idx[k];
      end
    end
  end

  assign grant_any = |req;

endmodule

// File: rtl/adder_share_sched.sv
// adder_share_sched
//   Shares one multi-cycle adder among NUM_REQ requesters. One operation is
//   in flight at a time: grant (round-robin), issue operands to the adder,
//   wait for its result (or time out), present the tagged response, then
//   pulse the adder reset before the next grant.
//   Ports:
//     CLK   in  clock
//     RST   in  synchronous active-high reset; also forces ADD_RST high
//     bus   adder_share_sched_if.slave: request handshakes, response
//           channel, adder connection and OP_COUNT
module adder_share_sched
  import adder_share_sched_pkg::*;
#(
  parameter int ADDER_WIDTH    = 4,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               CLK,
  input  logic               RST,
  adder_share_sched_if.slave bus
);

  localparam int ID_W    = id_width(NUM_REQ);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

  state_t                 state_reg, state_next;
  logic [ID_W-1:0]        ptr_reg;
  logic [ID_W-1:0]        id_reg;
  logic [ADDER_WIDTH-1:0] op_a_reg, op_b_reg;
  logic [ADDER_WIDTH-1:0] rsp_data_reg;
  logic                   rsp_err_reg;
  logic [TIMER_W-1:0]     timer_reg;
  logic [15:0]            op_count_reg;

  logic [ID_W-1:0]        arb_idx;
  logic                   arb_any;
  logic                   grant_fire;
  logic                   rsp_fire;
  logic                   timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (bus.REQ_VALID),
    .ptr       (ptr_reg),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  assign timeout_hit = (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and the strobe-style outputs. Strobes are masked by RST so
  // that every output sits at its reset value while reset is held.
  always_comb begin
    state_next         = state_reg;
    grant_fire         = 1'b0;
    rsp_fire           = 1'b0;
    bus.REQ_READY      = '0;
    bus.ADD_VAL1_VALID = 1'b0;
    bus.ADD_VAL2_VALID = 1'b0;
    bus.RSP_VALID      = 1'b0;
    bus.ADD_RST        = RST;
    unique case (state_reg)
      ST_IDLE: begin
        if (arb_any && bus.ADD_IS_READY && !RST) begin
          grant_fire    = 1'b1;
          bus.REQ_READY = NUM_REQ'(1) << arb_idx;
          state_next    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus.ADD_VAL1_VALID = !RST;
        bus.ADD_VAL2_VALID = !RST;
        state_next         = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.ADD_OUTPUT_VALID || timeout_hit) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.RSP_VALID = !RST;
        if (bus.RSP_READY) begin
          rsp_fire   = 1'b1;
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        bus.ADD_RST = 1'b1;
        state_next  = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_reg      <= '0;
      id_reg       <= '0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
      timer_reg    <= '0;
      op_count_reg <= '0;
    end else begin
      if (grant_fire) begin
        op_a_reg <= bus.REQ_A[arb_idx*ADDER_WIDTH +: ADDER_WIDTH];
        op_b_reg <= bus.REQ_B[arb_idx*ADDER_WIDTH +: ADDER_WIDTH];
        id_reg   <= arb_idx;
        ptr_reg  <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
      end
      if (state_reg == ST_ISSUE) begin
        timer_reg <= '0;
      end
      if (state_reg == ST_WAIT) begin
        // A result arriving on the timeout cycle is still delivered.
        if (bus.ADD_OUTPUT_VALID) begin
          rsp_data_reg <= bus.ADD_OUTPUT_VAL;
          rsp_err_reg  <= 1'b0;
        end else if (timeout_hit) begin
          rsp_data_reg <= '0;
          rsp_err_reg  <= 1'b1;
        end else begin
          timer_reg <= timer_reg + TIMER_W'(1);
        end
      end
      if (rsp_fire) begin
        op_count_reg <= op_count_reg + 16'd1;
      end
    end
  end

  // Operands stay on the adder bus after the issue cycle.
  assign bus.ADD_VAL1 = op_a_reg;
  assign bus.ADD_VAL2 = op_b_reg;
  assign bus.RSP_ID   = id_reg;
  assign bus.RSP_DATA = rsp_data_reg;
  assign bus.RSP_ERR  = rsp_err_reg;
  assign bus.OP_COUNT = op_count_reg;

endmodule

// File: tb/tb_adder_share_sched.sv
// tb_adder_share_sched
//   Self-checking bench for adder_share_sched with a latency-programmable
//   adder model, requester models and a response scoreboard.
module tb_adder_share_sched;
  localparam int AW = 4;
  localparam int NR = 4;
  localparam int TO = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  adder_share_sched_if #(.ADDER_WIDTH(AW), .NUM_REQ(NR)) bus();

  adder_share_sched #(
    .ADDER_WIDTH    (AW),
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Adder model: result visible in WAIT cycle number mdl_lat after issue.
  logic       mdl_busy      = 1'b0;
  logic       mdl_out_valid = 1'b0;
  logic [3:0] mdl_sum       = 4'h0;
  int         mdl_cnt       = 0;
  int         mdl_lat       = 1;
  bit         mdl_never     = 1'b0;
  bit         force_busy    = 1'b0;

  assign bus.ADD_IS_READY     = !mdl_busy && !force_busy;
  assign bus.ADD_OUTPUT_VALID = mdl_out_valid;
  assign bus.ADD_OUTPUT_VAL   = mdl_sum;

  always @(posedge CLK) begin
    if (bus.ADD_RST) begin
      mdl_busy      <= 1'b0;
      mdl_out_valid <= 1'b0;
      mdl_cnt       <= 0;
      mdl_sum       <= 4'h0;
    end else if (bus.ADD_VAL1_VALID && bus.ADD_VAL2_VALID) begin
      mdl_busy      <= 1'b1;
      mdl_sum       <= bus.ADD_VAL1 + bus.ADD_VAL2;
      mdl_cnt       <= mdl_lat;
      mdl_out_valid <= !mdl_never && (mdl_lat == 0);
    end else if (mdl_busy && !mdl_out_valid && !mdl_never) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt <= 1) mdl_out_valid <= 1'b1;
    end
  end

  typedef struct {
    logic [1:0] id;
    logic [3:0] data;
    logic       err;
  } rsp_t;

  typedef struct {
    logic [3:0]  add_mask;
    logic [15:0] a_flat;
    logic [15:0] b_flat;
    int          lat;
    logic [1:0]  exp_id;
    logic [3:0]  exp_data;
  } vec_t;

  rsp_t sb[$];
  vec_t vecs[8];

  int errors = 0;
  int checks = 0;
  int n_rsp = 0;
  int exp_op_count = 0;
  bit clear_next = 1'b0;

  logic [3:0]  req_valid = 4'h0;
  logic [15:0] req_a = 16'h0;
  logic [15:0] req_b = 16'h0;

  logic [3:0] s_rr;
  logic       s_rv;
  logic       s_strobe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req();
    bus.REQ_VALID = req_valid;
    bus.REQ_A     = req_a;
    bus.REQ_B     = req_b;
  endtask

  task automatic add_req(input logic [3:0] mask, input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < NR; i++) begin
      if (mask[i]) begin
        req_valid[i]      = 1'b1;
        req_a[i*AW +: AW] = a[i*AW +: AW];
        req_b[i*AW +: AW] = b[i*AW +: AW];
      end
    end
    drive_req();
  endtask

  // One clock: sample before the edge, then account for the handshakes
  // that edge completed (grants retire requests, responses are scored).
  task automatic cycle();
    logic       hs;
    logic [1:0] id;
    logic [3:0] d;
    logic       e;
    rsp_t       ex;
    #1;
    s_rr     = bus.REQ_READY;
    s_rv     = bus.RSP_VALID;
    s_strobe = bus.ADD_VAL1_VALID && bus.ADD_VAL2_VALID;
    hs       = s_rv && bus.RSP_READY;
    id       = bus.RSP_ID;
    d        = bus.RSP_DATA;
    e        = bus.RSP_ERR;
    chk("req_ready_onehot", 32'((s_rr & (s_rr - 4'd1)) != 4'd0), 32'd0);
    @(posedge CLK);
    #1;
    if (s_rr != 4'h0) begin
      req_valid = req_valid & ~s_rr;
      drive_req();
    end
    if (hs) begin
      n_rsp++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d data=%0h err=%0b expected none", id, d, e);
      end else begin
        ex = sb.pop_front();
        if (id !== ex.id || d !== ex.data || e !== ex.err) begin
          errors++;
          $display("FAIL rsp: got id=%0d data=%0h err=%0b expected id=%0d data=%0h err=%0b",
                   id, d, e, ex.id, ex.data, ex.err);
        end else begin
          $display("rsp id=%0d data=%0h err=%0b ok", id, d, e);
        end
      end
      exp_op_count++;
      chk("op_count", 32'(bus.OP_COUNT), 32'(exp_op_count));
      chk("add_rst_clear", 32'(bus.ADD_RST), 32'd1);
      clear_next = 1'b1;
    end else if (clear_next) begin
      chk("add_rst_after_clear", 32'(bus.ADD_RST), 32'd0);
      clear_next = 1'b0;
    end
  endtask

  task automatic run_until_rsp(input int budget);
    int start;
    start = n_rsp;
    for (int k = 0; k < budget && n_rsp == start; k++) cycle();
    chk("rsp_arrived", 32'(n_rsp != start), 32'd1);
  endtask

  task automatic wait_strobe(input int budget);
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!s_strobe && k < budget);
    chk("issue_strobe_seen", 32'(s_strobe), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{4'b0001, 16'h0003, 16'h0004, 2, 2'd0, 4'h7};
    vecs[1] = '{4'b1000, 16'hF000, 16'h2000, 1, 2'd3, 4'h1};
    vecs[2] = '{4'b1111, 16'h7195, 16'h8096, 3, 2'd0, 4'hB};
    vecs[3] = '{4'b0000, 16'h0000, 16'h0000, 0, 2'd1, 4'h2};
    vecs[4] = '{4'b0000, 16'h0000, 16'h0000, 4, 2'd2, 4'h1};
    vecs[5] = '{4'b0000, 16'h0000, 16'h0000, 1, 2'd3, 4'hF};
    vecs[6] = '{4'b0101, 16'h0802, 16'h0802, 0, 2'd0, 4'h4};
    vecs[7] = '{4'b0000, 16'h0000, 16'h0000, 2, 2'd2, 4'h0};

    bus.RSP_READY = 1'b1;
    drive_req();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_add_rst", 32'(bus.ADD_RST), 32'd1);
    chk("rst_req_ready", 32'(bus.REQ_READY), 32'd0);
    chk("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    chk("rst_rsp_id", 32'(bus.RSP_ID), 32'd0);
    chk("rst_rsp_data", 32'(bus.RSP_DATA), 32'd0);
    chk("rst_rsp_err", 32'(bus.RSP_ERR), 32'd0);
    chk("rst_add_val1", 32'(bus.ADD_VAL1), 32'd0);
    chk("rst_add_valid", 32'(bus.ADD_VAL1_VALID | bus.ADD_VAL2_VALID), 32'd0);
    chk("rst_op_count", 32'(bus.OP_COUNT), 32'd0);
    RST = 1'b0;
    #1;
    chk("add_rst_released", 32'(bus.ADD_RST), 32'd0);

    // Table: single request, overflow, contention 0..3, then 0101 -> 0,2.
    for (int v = 0; v < 8; v++) begin
      mdl_lat   = vecs[v].lat;
      mdl_never = 1'b0;
      add_req(vecs[v].add_mask, vecs[v].a_flat, vecs[v].b_flat);
      sb.push_back('{vecs[v].exp_id, vecs[v].exp_data, 1'b0});
      run_until_rsp(60);
    end

    // Timeout: adder never answers; sixteen WAIT cycles then an error.
    mdl_never = 1'b1;
    add_req(4'b0010, 16'h0010, 16'h0010);
    sb.push_back('{2'd1, 4'h0, 1'b1});
    wait_strobe(20);
    n = 0;
    while (n < 40) begin
      cycle();
      if (s_rv) break;
      n++;
    end
    chk("timeout_wait_cycles", 32'(n), 32'(TO));
    mdl_never = 1'b0;

    // Result arriving on the timeout cycle wins.
    mdl_lat = TO - 1;
    add_req(4'b0001, 16'h0006, 16'h0003);
    sb.push_back('{2'd0, 4'h9, 1'b0});
    run_until_rsp(60);

    // Back-pressure with another request pending.
    mdl_lat = 1;
    bus.RSP_READY = 1'b0;
    add_req(4'b0101, 16'h0401, 16'h0501);
    sb.push_back('{2'd2, 4'h9, 1'b0});
    sb.push_back('{2'd0, 4'h2, 1'b0});
    for (int k = 0; k < 40 && !bus.RSP_VALID; k++) cycle();
    chk("bp_valid_seen", 32'(bus.RSP_VALID), 32'd1);
    repeat (5) begin
      cycle();
      chk("bp_valid_hold", 32'(bus.RSP_VALID), 32'd1);
      chk("bp_id_hold", 32'(bus.RSP_ID), 32'd2);
      chk("bp_data_hold", 32'(bus.RSP_DATA), 32'h9);
      chk("bp_no_grant", 32'(bus.REQ_READY), 32'd0);
      chk("bp_no_add_rst", 32'(bus.ADD_RST), 32'd0);
    end
    bus.RSP_READY = 1'b1;
    run_until_rsp(20);
    run_until_rsp(40);

    // Adder not ready: request must wait.
    force_busy = 1'b1;
    mdl_lat = 2;
    add_req(4'b0010, 16'h0030, 16'h0040);
    sb.push_back('{2'd1, 4'h7, 1'b0});
    repeat (3) begin
      cycle();
      chk("notready_no_grant", 32'(bus.REQ_READY), 32'd0);
    end
    force_busy = 1'b0;
    run_until_rsp(40);

    // Reset during WAIT drops the operation and resets the pointer.
    mdl_never = 1'b1;
    add_req(4'b0100, 16'h0100, 16'h0200);
    wait_strobe(20);
    repeat (3) cycle();
    RST = 1'b1;
    cycle();
    chk("midrst_req_ready", 32'(bus.REQ_READY), 32'd0);
    chk("midrst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    chk("midrst_rsp_id", 32'(bus.RSP_ID), 32'd0);
    chk("midrst_rsp_data", 32'(bus.RSP_DATA), 32'd0);
    chk("midrst_rsp_err", 32'(bus.RSP_ERR), 32'd0);
    chk("midrst_add_val1", 32'(bus.ADD_VAL1), 32'd0);
    chk("midrst_add_val2", 32'(bus.ADD_VAL2), 32'd0);
    chk("midrst_add_valid", 32'(bus.ADD_VAL1_VALID | bus.ADD_VAL2_VALID), 32'd0);
    chk("midrst_add_rst", 32'(bus.ADD_RST), 32'd1);
    chk("midrst_op_count", 32'(bus.OP_COUNT), 32'd0);
    exp_op_count = 0;
    clear_next = 1'b0;
    sb.delete();
    RST = 1'b0;
    mdl_never = 1'b0;
    mdl_lat = 1;
    add_req(4'b1010, 16'h4020, 16'h4030);
    sb.push_back('{2'd1, 4'h5, 1'b0});
    sb.push_back('{2'd3, 4'h8, 1'b0});
    run_until_rsp(40);
    run_until_rsp(40);
    chk("final_op_count", 32'(bus.OP_COUNT), 32'd2);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_share_sched.md
Name: adder_share_sched

Overview:
- Round-robin scheduler that shares one multi-cycle Kogge-Stone adder instance among NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes, issues one operation at a time and waits for the adder's result.
- Returns the result, tagged with the requester index, then pulses the adder's reset so it is ready for the next operation.
- Sits between the requesting blocks and the adder in the information-flow test designs.

Parameters:
- ADDER_WIDTH, 4, operand/result width; must match the adder instance.
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 16, WAIT-state cycles before an operation is aborted (>= 4).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- REQ_VALID  in  NUM_REQ  per-requester operand-pair valid
- REQ_A  in  NUM_REQ*ADDER_WIDTH  flattened operand A; requester i uses slice [i*ADDER_WIDTH +: ADDER_WIDTH]
- REQ_B  in  NUM_REQ*ADDER_WIDTH  flattened operand B, same slicing
- REQ_READY  out  NUM_REQ  one-hot accept pulse
- RSP_VALID  out  1  result valid
- RSP_READY  in  1  result consumer ready
- RSP_ID  out  $clog2(NUM_REQ)  index of the requester owning the result
- RSP_DATA  out  ADDER_WIDTH  sum (mod 2^ADDER_WIDTH)
- RSP_ERR  out  1  operation timed out; RSP_DATA=0
- ADD_VAL1, ADD_VAL2  out  ADDER_WIDTH each  operands to adder
- ADD_VAL1_VALID, ADD_VAL2_VALID  out  1 each  operand strobes to adder
- ADD_RST  out  1  adder reset
- ADD_IS_READY  in  1  from adder
- ADD_OUTPUT_VAL  in  ADDER_WIDTH  from adder
- ADD_OUTPUT_VALID  in  1  from adder
- OP_COUNT  out  16  completed operations (including timeouts); wraps at 2^16

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: state=IDLE, REQ_READY=0, RSP_VALID=0, RSP_ID=0, RSP_DATA=0, RSP_ERR=0, ADD_VAL*=0, ADD_VAL*_VALID=0, OP_COUNT=0, round-robin pointer=0. ADD_RST=1 while RST is high (combinational OR with the CLEAR-state pulse).
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> CLEAR -> IDLE.
- IDLE:
  - Grant requires |REQ_VALID && ADD_IS_READY.
  - Grant g = first set bit of REQ_VALID, searching circularly from pointer.
  - On grant: REQ_READY[g]=1 for exactly that cycle (transfer occurs); latch REQ_A/REQ_B slices and g; pointer <= (g+1) mod NUM_REQ; go to ISSUE.
  - No grant if ADD_IS_READY=0.
- ISSUE:
  - Drive latched operands on ADD_VAL1/2; ADD_VAL1_VALID=ADD_VAL2_VALID=1 for this single cycle.
  - Clear timer; go to WAIT.
- WAIT:
  - Operand outputs hold; valids are 0.
  - If ADD_OUTPUT_VALID: RSP_DATA<=ADD_OUTPUT_VAL, RSP_ERR<=0, go to RESP.
  - Else timer++. When timer==TIMEOUT_CYCLES-1: RSP_DATA<=0, RSP_ERR<=1, go to RESP.
  - If ADD_OUTPUT_VALID and the timeout hit coincide, the valid result wins.
- RESP:
  - RSP_VALID=1 and RSP_ID/RSP_DATA/RSP_ERR stay stable until RSP_READY.
  - The cycle RSP_VALID && RSP_READY: OP_COUNT++, go to CLEAR.
- CLEAR:
  - ADD_RST=1 for exactly one cycle; then IDLE.
  - The earliest next grant is the cycle after CLEAR, and still requires ADD_IS_READY.
- Latency: minimum accept-to-RSP_VALID is ISSUE(1) + adder latency + 1.
- Throughput: at most one operation in flight.
- REQ_VALID deasserting while not granted is legal; no request is lost once REQ_READY has pulsed.
- REQ_READY is never asserted outside IDLE.
- RST mid-operation: abort immediately, drop the pending result, and drive all outputs to reset values.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=0, ISSUE=1, WAIT=2, RESP=3, CLEAR=4);
  - the ID width function $clog2(NUM_REQ).
- One sub-module, rr_arbiter: NUM_REQ-wide round-robin priority encoder.
  - Inputs: request vector, pointer.
  - Outputs: grant index, any-grant.
  - Purely combinational.
- FSM, timer, operand/response registers and OP_COUNT live in adder_share_sched.

Test Plan:
- Single request: REQ_VALID=0001, A=3, B=4 with adder model → REQ_READY=0001 for one cycle, one ISSUE strobe, RSP_VALID with RSP_ID=0, RSP_DATA=7, RSP_ERR=0; ADD_RST pulses one cycle after the response handshake; OP_COUNT=1.
- Contention: REQ_VALID=1111 held for four operations with pointer=0 → grants in order 0,1,2,3. Next request 0101 → grants 0 then 2.
- Overflow: A=0xF, B=0x2 → RSP_DATA=0x1.
- Back-pressure: RSP_READY=0 for 5 cycles → RSP_VALID, RSP_DATA and RSP_ID held stable; no REQ_READY pulse; no ADD_RST until the handshake.
- Timeout: adder model never asserts OUTPUT_VALID with TIMEOUT_CYCLES=16 → RSP_ERR=1 and RSP_DATA=0 sixteen cycles after ISSUE. Test also the case where OUTPUT_VALID and timeout coincide → RSP_ERR=0.
- RST asserted during WAIT → next cycle all outputs at reset values with ADD_RST=1. After release, a new request is granted starting from pointer 0.
